io_input_conditioner: RTL and testbench
=======================================

# io_input_conditioner

Parametrised synchronise/debounce/edge-detect block for asynchronous board inputs (buttons, switches) ahead of the OTTER MMIO input ports. Generalises per-input conditioning to N_CH channels:
- two-flop (or deeper) synchroniser;
- counter-based debounce;
- one-cycle rise/fall pulses and per-channel toggle state;
- sticky rise-event register with a single interrupt line, cleared by a mask from the MCU side.

## Interface
- N_CH, default 16: number of input channels (1..32).
- DEBOUNCE_CYCLES, default 1000000: consecutive cycles of a new synchronised level before it is accepted (≥1).
- SYNC_STAGES, default 2: synchroniser depth (≥2).
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- raw_in  input  N_CH  asynchronous board inputs.
- clr_mask  input  N_CH  clears selected bits of pending for one clk cycle.
- level  output  N_CH  debounced level.
- rise  output  N_CH  one-cycle pulse on accepted 0→1.
- fall  output  N_CH  one-cycle pulse on accepted 1→0.
- toggle  output  N_CH  flips on each accepted rise.
- pending  output  N_CH  sticky rise flags.
- irq  output  1  OR of pending.

## Operation
- Reset values: all synchroniser stages, counters, level, rise, fall, toggle, pending = 0; irq = 0.
- Synchroniser, per channel: shift raw_in through SYNC_STAGES flops; s = last stage.
- Debounce, per channel; counter width clog2(DEBOUNCE_CYCLES).
  - If s == level: cnt ← 0.
  - If s != level and cnt == DEBOUNCE_CYCLES−1: commit. level ← s, cnt ← 0.
  - Otherwise cnt ← cnt+1.
  - A mismatch interrupted by even one matching cycle restarts the count (glitch rejection).
- On a commit cycle, registered in the same edge as level:
  - rise ← s; fall ← ~s.
  - On rise: toggle ← ~toggle.
- rise and fall are 0 on every non-commit cycle. They are never both 1 on one channel.
- pending[i], next value: (pending[i] & ~clr_mask[i]) | rise_next[i].
  - Set wins over a simultaneous clear.
- irq = |pending, combinational from the register (no extra latency).
- Channels are fully independent. Simultaneous commits on several channels are all reported in the same cycle.
- Reset asserted mid-count: the count is discarded. After release, a held input is re-accepted after the full latency; rise fires if the held level is 1.

## Timing
- Total latency = SYNC_STAGES + DEBOUNCE_CYCLES rising edges.
  - Start: raw_in is stable before edge 1.
  - End: level, rise/fall, toggle, pending and irq all update on that edge.
- Pulses: exactly one clk cycle wide.
- clr_mask: takes effect on the next edge. irq drops the same edge if no other pending bits remain.
- Re-triggering: a steady level produces no further pulses.

## Structure
- Shared package otter_io_pkg holds:
  - default constants IO_N_CH = 16, IO_DEBOUNCE_CYCLES = 1000000, IO_SYNC_STAGES = 2;
  - localparam function for the counter width.
- Sub-module debounce_channel: one channel's synchroniser, counter, level, rise/fall and toggle; parameterised by DEBOUNCE_CYCLES and SYNC_STAGES.
- Top generates N_CH instances and implements pending/irq.

## Test plan
Parameters: N_CH=5, DEBOUNCE_CYCLES=4, SYNC_STAGES=2; latency 6 edges.
- Reset: assert rst with raw_in=5'b11111 → all outputs 0 immediately, no clk needed. Release → level=5'b11111 exactly 6 edges later, rise=5'b11111 for 1 cycle, pending=5'b11111, irq=1.
- Clean press/release: raw_in[0] 0→1 held 20 cycles → level[0] rises at edge 6 with a 1-cycle rise[0] and toggle[0]=1. Release → level[0] falls 6 edges later with a 1-cycle fall[0]; toggle stays 1.
- Bounce rejection: raw_in[1] pulses high 3 cycles, low 1, high 3, then low → level[1], rise[1] and pending[1] remain 0 throughout.
- Pending/clear: rise on ch2 → pending=5'b00100, irq=1. clr_mask=5'b00100 for one cycle → pending=0, irq=0 next edge. Clear coinciding with a new rise on ch2 → pending[2] stays 1.
- Simultaneous channels: raw_in 5'b00000→5'b11000 → rise=5'b11000 on the same cycle, pending=5'b11000.
- Reset mid-count: raw_in[3]=1; assert rst after 4 edges; release; hold → level[3] rises 6 edges after release, not earlier.

Source files
------------

// File: rtl/otter_io_pkg.sv
// Shared defaults and helpers for the OTTER MMIO input-conditioning blocks.
package otter_io_pkg;

  localparam int IO_N_CH            = 16;
  localparam int IO_DEBOUNCE_CYCLES = 1000000;
  localparam int IO_SYNC_STAGES     = 2;

  // A one-cycle debounce still needs a 1-bit counter to stay a legal vector.
  function automatic int io_cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: synchroniser, counter debounce, level, rise/fall pulses and toggle.
module debounce_channel
  import otter_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = IO_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = IO_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic toggle_o,
  output logic rise_nxt_o
);

  localparam int CW = io_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   toggle_q, toggle_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    // NOTE: every next-state signal takes a default first so no path leaves it unassigned (no latch).
    sync_d   = {sync_q[SYNC_STAGES-2:0], raw_i};
    cnt_d    = cnt_q;
    level_d  = level_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    toggle_d = toggle_q;
    if (s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d    = '0;
      level_d  = s;
      rise_d   = s;
      fall_d   = ~s;
      toggle_d = toggle_q ^ s;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
    if (rst) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      toggle_q <= toggle_d;
    end
  end

  assign level_o    = level_q;
  assign rise_o     = rise_q;
  assign fall_o     = fall_q;
  assign toggle_o   = toggle_q;
  assign rise_nxt_o = rise_d;

endmodule

// File: rtl/io_input_conditioner.sv
// N_CH independent debounced inputs plus a sticky rise-event register driving one irq line.
module io_input_conditioner
  import otter_io_pkg::*;
#(
  parameter int N_CH            = IO_N_CH,
  parameter int DEBOUNCE_CYCLES = IO_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = IO_SYNC_STAGES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] raw_in,
  input  logic [N_CH-1:0] clr_mask,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] toggle,
  output logic [N_CH-1:0] pending,
  output logic            irq
);

  logic [N_CH-1:0] rise_nxt;
  logic [N_CH-1:0] pending_q, pending_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .raw_i     (raw_in[i]),
      .level_o   (level[i]),
      .rise_o    (rise[i]),
      .fall_o    (fall[i]),
      .toggle_o  (toggle[i]),
      .rise_nxt_o(rise_nxt[i])
    );
  end

  // A rise landing on the same edge as a clear must survive, so the set term is ORed last.
  assign pending_d = (pending_q & ~clr_mask) | rise_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  assign pending = pending_q;
  assign irq     = |pending_q;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench for io_input_conditioner with N_CH=5, DEBOUNCE_CYCLES=4, SYNC_STAGES=2 (6-edge latency).
module tb_io_input_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] raw_in = '0;
  logic [4:0] clr_mask = '0;
  logic [4:0] level, rise, fall, toggle, pending;
  logic       irq;
  logic [25:0] all_o;
  logic [25:0] exp_o;
  int checks = 0;
  int errors = 0;

  io_input_conditioner #(
    .N_CH(5), .DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .raw_in(raw_in), .clr_mask(clr_mask),
    .level(level), .rise(rise), .fall(fall), .toggle(toggle),
    .pending(pending), .irq(irq)
  );

  always #5 clk = ~clk;

  // {level, rise, fall, toggle, pending, irq}
  assign all_o = {level, rise, fall, toggle, pending, irq};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [4:0] r);
    raw_in = r;
    clr_mask = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    raw_in = 5'b11111;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (all_o !== 26'd0) begin
      errors++;
      $display("FAIL reset_async got=%h exp=%h", all_o, 26'd0);
    end
    step();
    step();
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++;
      if (level !== 5'd0 || rise !== 5'd0 || pending !== 5'd0) begin
        errors++;
        $display("FAIL reset_early edge=%0d got=%h exp level/rise/pending 0", k, all_o);
      end
    end
    step();
    exp_o = {5'b11111, 5'b11111, 5'b00000, 5'b11111, 5'b11111, 1'b1};
    checks++;
    if (all_o !== exp_o) begin
      errors++;
      $display("FAIL reset_accept got=%h exp=%h", all_o, exp_o);
    end
    step();
    exp_o = {5'b11111, 5'b00000, 5'b00000, 5'b11111, 5'b11111, 1'b1};
    checks++;
    if (all_o !== exp_o) begin
      errors++;
      $display("FAIL reset_pulse_end got=%h exp=%h", all_o, exp_o);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (all_o !== 26'd0) begin
      errors++;
      $display("FAIL reset_async_nonzero got=%h exp=%h", all_o, 26'd0);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_clean_press();
    do_reset(5'b00000);
    raw_in = 5'b00001;
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++;
      if (level !== 5'd0 || rise !== 5'd0) begin
        errors++;
        $display("FAIL press_early edge=%0d got=%h exp level/rise 0", k, all_o);
      end
    end
    step();
    exp_o = {5'b00001, 5'b00001, 5'b00000, 5'b00001, 5'b00001, 1'b1};
    checks++;
    if (all_o !== exp_o) begin
      errors++;
      $display("FAIL press_accept got=%h exp=%h", all_o, exp_o);
    end
    exp_o = {5'b00001, 5'b00000, 5'b00000, 5'b00001, 5'b00001, 1'b1};
    for (int k = 0; k < 14; k++) begin
      step();
      checks++;
      if (all_o !== exp_o) begin
        errors++;
        $display("FAIL press_hold cyc=%0d got=%h exp=%h", k, all_o, exp_o);
      end
    end
    raw_in = 5'b00000;
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++;
      if (level !== 5'b00001 || fall !== 5'd0) begin
        errors++;
        $display("FAIL release_early edge=%0d got=%h exp level=01 fall=0", k, all_o);
      end
    end
    step();
    exp_o = {5'b00000, 5'b00000, 5'b00001, 5'b00001, 5'b00001, 1'b1};
    checks++;
    if (all_o !== exp_o) begin
      errors++;
      $display("FAIL release_accept got=%h exp=%h", all_o, exp_o);
    end
    step();
    exp_o = {5'b00000, 5'b00000, 5'b00000, 5'b00001, 5'b00001, 1'b1};
    checks++;
    if (all_o !== exp_o) begin
      errors++;
      $display("FAIL release_pulse_end got=%h exp=%h", all_o, exp_o);
    end
  endtask

  task automatic test_bounce();
    logic [4:0] pat [17];
    pat = '{5'b00010, 5'b00010, 5'b00010, 5'b00000, 5'b00010, 5'b00010,
            5'b00010, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000,
            5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
    do_reset(5'b00000);
    for (int k = 0; k < 17; k++) begin
      raw_in = pat[k];
      step();
      checks++;
      if (((level | rise | pending) & 5'b00010) !== 5'd0) begin
        errors++;
        $display("FAIL bounce cyc=%0d got=%h exp ch1 quiet", k, all_o);
      end
    end
  endtask

  task automatic test_pending_clear();
    do_reset(5'b00000);
    raw_in = 5'b00100;
    repeat (6) step();
    checks++;
    if ({rise, pending, irq} !== {5'b00100, 5'b00100, 1'b1}) begin
      errors++;
      $display("FAIL pend_set got=%h exp rise=04 pend=04 irq=1", all_o);
    end
    clr_mask = 5'b00100;
    step();
    clr_mask = 5'b00000;
    checks++;
    if ({pending, irq} !== {5'b00000, 1'b0}) begin
      errors++;
      $display("FAIL pend_clear got=%h exp pend=00 irq=0", all_o);
    end
    raw_in = 5'b00000;
    repeat (6) step();
    checks++;
    if ({fall, pending, irq} !== {5'b00100, 5'b00000, 1'b0}) begin
      errors++;
      $display("FAIL pend_fall got=%h exp fall=04 pend=00 irq=0", all_o);
    end
    raw_in = 5'b00100;
    repeat (5) step();
    clr_mask = 5'b00100;
    step();
    clr_mask = 5'b00000;
    checks++;
    if ({rise, pending, irq} !== {5'b00100, 5'b00100, 1'b1}) begin
      errors++;
      $display("FAIL pend_set_wins got=%h exp rise=04 pend=04 irq=1", all_o);
    end
  endtask

  task automatic test_simultaneous();
    do_reset(5'b00000);
    raw_in = 5'b11000;
    repeat (5) step();
    checks++;
    if (level !== 5'd0) begin
      errors++;
      $display("FAIL simul_early got=%h exp level=00", all_o);
    end
    step();
    exp_o = {5'b11000, 5'b11000, 5'b00000, 5'b11000, 5'b11000, 1'b1};
    checks++;
    if (all_o !== exp_o) begin
      errors++;
      $display("FAIL simul_accept got=%h exp=%h", all_o, exp_o);
    end
    clr_mask = 5'b01000;
    step();
    checks++;
    if ({pending, irq} !== {5'b10000, 1'b1}) begin
      errors++;
      $display("FAIL simul_partial_clear got=%h exp pend=10 irq=1", all_o);
    end
    clr_mask = 5'b10000;
    step();
    clr_mask = 5'b00000;
    checks++;
    if ({pending, irq} !== {5'b00000, 1'b0}) begin
      errors++;
      $display("FAIL simul_full_clear got=%h exp pend=00 irq=0", all_o);
    end
  endtask

  task automatic test_reset_mid_count();
    do_reset(5'b00000);
    raw_in = 5'b01000;
    repeat (4) step();
    rst = 1'b1;
    #1;
    checks++;
    if (all_o !== 26'd0) begin
      errors++;
      $display("FAIL midrst_async got=%h exp=%h", all_o, 26'd0);
    end
    step();
    step();
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++;
      if (level !== 5'd0 || rise !== 5'd0) begin
        errors++;
        $display("FAIL midrst_early edge=%0d got=%h exp level/rise 0", k, all_o);
      end
    end
    step();
    exp_o = {5'b01000, 5'b01000, 5'b00000, 5'b01000, 5'b01000, 1'b1};
    checks++;
    if (all_o !== exp_o) begin
      errors++;
      $display("FAIL midrst_accept got=%h exp=%h", all_o, exp_o);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_pending_clear();
    test_simultaneous();
    test_reset_mid_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
